// File: rtl/lf_clkdiv_prog.sv
// lf_clkdiv_prog
//   Programmable low-frequency clock divider for the LPF/downsampler path.
//   Divides clk_625mhz_s by an even, run-time ratio into a 50% duty clk_lf_o
//   and emits a one-cycle lf_strobe_o in the cycle clk_lf_o rises. Ratio
//   changes made while running are held in a shadow register and applied
//   only on a period boundary, so clk_lf_o never glitches.
//
// Ports
//   clk_625mhz_s  in   clock
//   por_rstn_s    in   asynchronous active-low reset
//   enable_i      in   run request (level)
//   div_ratio_i   in   requested divide ratio (CNT_W)
//   div_load_i    in   one-cycle pulse, load div_ratio_i
//   clk_lf_o      out  divided clock (registered)
//   lf_strobe_o   out  one-cycle pulse on each clk_lf_o rising edge
//   div_busy_o    out  legal ratio pending, not yet applied
//   div_err_o     out  sticky: last load was illegal
//   cur_ratio_o   out  ratio currently in use (CNT_W)
//   period_cnt_o  out  completed clk_lf_o periods, saturating (LF_PERIOD_CNT_EN only)
//
// Build option
//   LF_PERIOD_CNT_EN : adds period_cnt_o and its counter.
//
// States
//   IDLE | cnt held at 0, clk_lf_o low
//   RUN  | counting 0..R-1, enable_i high
//   STOP | enable dropped, finishing the current period
module lf_clkdiv_prog #(
  parameter int CNT_W       = 6,
  parameter int DIV_DEFAULT = 16
) (
  input  logic             clk_625mhz_s,
  input  logic             por_rstn_s,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] div_ratio_i,
  input  logic             div_load_i,
  output logic             clk_lf_o,
  output logic             lf_strobe_o,
  output logic             div_busy_o,
  output logic             div_err_o,
  output logic [CNT_W-1:0] cur_ratio_o
`ifdef LF_PERIOD_CNT_EN
  ,
  output logic [15:0]      period_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] DIV_DEF_C = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] ZERO_C    = '0;
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ratio_q, ratio_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             clk_lf_q, clk_lf_d;
  logic             strobe_q, strobe_d;

  logic             load_legal;
  logic             load_bad;
  logic             wrap;
  logic             apply;

  // Even and non-zero is the same as even and >= 2.
  assign load_legal = div_load_i && !div_ratio_i[0] && (div_ratio_i != ZERO_C);
  assign load_bad   = div_load_i && !load_legal;
  assign wrap       = (state_q != ST_IDLE) && (cnt_q == (ratio_q - ONE_C));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ratio_d  = ratio_q;
    shadow_d = shadow_q;
    busy_d   = busy_q;
    err_d    = err_q;
    apply    = 1'b0;

    if (load_legal) begin
      err_d = 1'b0;
    end else if (load_bad) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = ZERO_C;
        if (load_legal) begin
          ratio_d  = div_ratio_i;
          shadow_d = div_ratio_i;
          apply    = 1'b1;
        end
        if (enable_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_STOP: begin
        if (load_legal) begin
          shadow_d = div_ratio_i;
        end
        if (wrap) begin
          cnt_d  = ZERO_C;
          busy_d = 1'b0;
          // A load landing on the wrap cycle itself bypasses the shadow.
          if (load_legal) begin
            ratio_d = div_ratio_i;
            apply   = 1'b1;
          end else if (busy_q) begin
            ratio_d = shadow_q;
            apply   = 1'b1;
          end
          state_d = enable_i ? ST_RUN : ST_IDLE;
        end else begin
          cnt_d = cnt_q + ONE_C;
          if (load_legal) begin
            busy_d = 1'b1;
          end
          state_d = enable_i ? ST_RUN : ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = ZERO_C;
      end
    endcase

    // Threshold uses the ratio of the period cnt_d belongs to, so a new
    // ratio takes effect from cnt=0 of the following period.
    clk_lf_d = (state_d != ST_IDLE) && (cnt_d < (ratio_d >> 1));
    strobe_d = clk_lf_d && !clk_lf_q;
  end

  always_ff @(posedge clk_625mhz_s or negedge por_rstn_s) begin
    if (!por_rstn_s) begin
      state_q  <= ST_IDLE;
      cnt_q    <= ZERO_C;
      ratio_q  <= DIV_DEF_C;
      shadow_q <= DIV_DEF_C;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      clk_lf_q <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ratio_q  <= ratio_d;
      shadow_q <= shadow_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      clk_lf_q <= clk_lf_d;
      strobe_q <= strobe_d;
    end
  end

  assign clk_lf_o    = clk_lf_q;
  assign lf_strobe_o = strobe_q;
  assign div_busy_o  = busy_q;
  assign div_err_o   = err_q;
  assign cur_ratio_o = ratio_q;

`ifdef LF_PERIOD_CNT_EN
  logic [15:0] pcnt_q;

  // A ratio change restarts the count; otherwise every wrap is one
  // completed period.
  always_ff @(posedge clk_625mhz_s or negedge por_rstn_s) begin
    if (!por_rstn_s) begin
      pcnt_q <= 16'd0;
    end else if (apply) begin
      pcnt_q <= 16'd0;
    end else if (wrap && (pcnt_q != 16'hFFFF)) begin
      pcnt_q <= pcnt_q + 16'd1;
    end
  end

  assign period_cnt_o = pcnt_q;
`else
  // No period counter in this build; apply is only used by it.
  logic unused_apply;
  assign unused_apply = apply;
`endif

endmodule

// File: tb/tb_lf_clkdiv_prog.sv
module tb_lf_clkdiv_prog;

  logic       clk_625mhz_s = 1'b0;
  logic       por_rstn_s   = 1'b0;
  logic       enable_i     = 1'b0;
  logic [5:0] div_ratio_i  = 6'd0;
  logic       div_load_i   = 1'b0;
  logic       clk_lf_o;
  logic       lf_strobe_o;
  logic       div_busy_o;
  logic       div_err_o;
  logic [5:0] cur_ratio_o;
`ifdef LF_PERIOD_CNT_EN
  logic [15:0] period_cnt_o;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int busy_seen;
  int hi, lo, ok, cnt, hcnt, scnt;

  typedef struct {
    int ld;
    int ratio;
    int err;
    int cur;
  } vec_t;
  vec_t tbl[9];

  lf_clkdiv_prog #(.CNT_W(6), .DIV_DEFAULT(16)) dut (
    .clk_625mhz_s (clk_625mhz_s),
    .por_rstn_s   (por_rstn_s),
    .enable_i     (enable_i),
    .div_ratio_i  (div_ratio_i),
    .div_load_i   (div_load_i),
    .clk_lf_o     (clk_lf_o),
    .lf_strobe_o  (lf_strobe_o),
    .div_busy_o   (div_busy_o),
    .div_err_o    (div_err_o),
    .cur_ratio_o  (cur_ratio_o)
`ifdef LF_PERIOD_CNT_EN
    ,
    .period_cnt_o (period_cnt_o)
`endif
  );

  always #5 clk_625mhz_s = ~clk_625mhz_s;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_625mhz_s);
    #1;
    if (div_busy_o) busy_seen = 1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until a strobe is seen; ok=0 if none within the budget.
  task automatic wait_strobe(output int found);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (lf_strobe_o) begin
        found = 1;
        break;
      end
    end
  endtask

  // Called on the sample where a period starts (clk just rose); returns
  // high and low lengths and stops on the next period start.
  task automatic meas(output int h, output int l);
    h = 0;
    l = 0;
    while (clk_lf_o && h < 200) begin
      h++;
      step();
    end
    while (!clk_lf_o && l < 200) begin
      l++;
      step();
    end
  endtask

  initial begin
    tbl[0] = '{1, 7,  1, 20};
    tbl[1] = '{1, 0,  1, 20};
    tbl[2] = '{0, 0,  1, 20};
    tbl[3] = '{1, 4,  0, 4};
    tbl[4] = '{1, 1,  1, 4};
    tbl[5] = '{1, 62, 0, 62};
    tbl[6] = '{1, 2,  0, 2};
    tbl[7] = '{1, 63, 1, 2};
    tbl[8] = '{1, 4,  0, 4};
    busy_seen = 0;

    // Reset values
    #23;
    check("rst_clk", clk_lf_o, 0);
    check("rst_strobe", lf_strobe_o, 0);
    check("rst_busy", div_busy_o, 0);
    check("rst_err", div_err_o, 0);
    check("rst_cur", cur_ratio_o, 16);
    @(negedge clk_625mhz_s);
    por_rstn_s = 1'b1;
    steps(3);
    check("idle_clk", clk_lf_o, 0);

    // Default ratio 16, first strobe one cycle after enable
    enable_i = 1'b1;
    step();
    check("start_clk", clk_lf_o, 1);
    check("start_strobe", lf_strobe_o, 1);
    meas(hi, lo);
    check("r16_hi", hi, 8);
    check("r16_lo", lo, 8);
    check("r16_strobe", lf_strobe_o, 1);

    // Load 6 at cnt=3 while running at 16
    steps(3);
    div_ratio_i = 6'd6; div_load_i = 1'b1;
    step();
    div_load_i = 1'b0;
    check("ld6_busy", div_busy_o, 1);
    check("ld6_cur_old", cur_ratio_o, 16);
    busy_seen = 0;
    cnt = 0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (!div_busy_o) cnt++;
      step();
      if (lf_strobe_o) begin ok = 1; break; end
    end
    check("ld6_wrap_seen", ok, 1);
    check("ld6_busy_until_wrap", cnt, 0);
    check("ld6_busy_clr", div_busy_o, 0);
    check("ld6_cur", cur_ratio_o, 6);
    meas(hi, lo);
    check("r6_hi", hi, 3);
    check("r6_lo", lo, 3);
    meas(hi, lo);
    check("r6_hi2", hi, 3);
    check("r6_lo2", lo, 3);

    // Move to 8, then drop enable at cnt=2
    div_ratio_i = 6'd8; div_load_i = 1'b1;
    step();
    div_load_i = 1'b0;
    wait_strobe(ok);
    check("ld8_wrap_seen", ok, 1);
    check("ld8_cur", cur_ratio_o, 8);
    steps(2);
    enable_i = 1'b0;
    hcnt = 0; scnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (clk_lf_o) hcnt++;
      if (lf_strobe_o) scnt++;
    end
    check("stop_hi_tail", hcnt, 1);
    check("stop_no_strobe", scnt, 0);
    check("stop_clk_low", clk_lf_o, 0);

    // Re-enable from IDLE, then drop and re-raise enable inside STOP
    enable_i = 1'b1;
    wait_strobe(ok);
    check("reen_strobe", ok, 1);
    steps(2);
    enable_i = 1'b0;
    step();
    enable_i = 1'b1;
    step();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      cnt++;
      if (lf_strobe_o) break;
    end
    check("stop_rerun_gap", cnt, 4);
    meas(hi, lo);
    check("rerun_hi", hi, 4);
    check("rerun_lo", lo, 4);

    // Load 10 in the wrap cycle (cnt=7)
    steps(7);
    busy_seen = 0;
    div_ratio_i = 6'd10; div_load_i = 1'b1;
    step();
    div_load_i = 1'b0;
    check("wrapld_strobe", lf_strobe_o, 1);
    check("wrapld_cur", cur_ratio_o, 10);
    meas(hi, lo);
    check("r10_hi", hi, 5);
    check("r10_lo", lo, 5);
    check("wrapld_no_busy", busy_seen, 0);

    // Two loads while pending: last legal one wins
    div_ratio_i = 6'd12; div_load_i = 1'b1;
    step();
    div_ratio_i = 6'd20;
    step();
    div_load_i = 1'b0;
    check("dbl_busy", div_busy_o, 1);
    check("dbl_cur_old", cur_ratio_o, 10);
    wait_strobe(ok);
    check("dbl_cur", cur_ratio_o, 20);
    check("dbl_busy_clr", div_busy_o, 0);
    meas(hi, lo);
    check("r20_hi", hi, 10);
    check("r20_lo", lo, 10);

    // Back to IDLE, then table of loads in IDLE
    enable_i = 1'b0;
    scnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (lf_strobe_o) scnt++;
    end
    check("idle2_no_strobe", scnt, 0);
    check("idle2_clk", clk_lf_o, 0);
    for (int i = 0; i < 9; i++) begin
      div_ratio_i = 6'(tbl[i].ratio);
      div_load_i  = (tbl[i].ld != 0);
      step();
      div_load_i  = 1'b0;
      check($sformatf("tbl%0d_err", i), div_err_o, tbl[i].err);
      check($sformatf("tbl%0d_cur", i), cur_ratio_o, tbl[i].cur);
      check($sformatf("tbl%0d_busy", i), div_busy_o, 0);
    end

    // Run at 4, illegal load while running
    enable_i = 1'b1;
    wait_strobe(ok);
    meas(hi, lo);
    check("r4_hi", hi, 2);
    check("r4_lo", lo, 2);
    div_ratio_i = 6'd5; div_load_i = 1'b1;
    step();
    div_load_i = 1'b0;
    check("run_bad_err", div_err_o, 1);
    check("run_bad_busy", div_busy_o, 0);
    check("run_bad_cur", cur_ratio_o, 4);

    // Enable drop with a load pending: applied at the final wrap
    div_ratio_i = 6'd6; div_load_i = 1'b1; enable_i = 1'b0;
    step();
    div_load_i = 1'b0;
    check("drop_busy", div_busy_o, 1);
    steps(10);
    check("drop_cur", cur_ratio_o, 6);
    check("drop_busy_clr", div_busy_o, 0);
    check("drop_clk", clk_lf_o, 0);
    check("drop_err_clr", div_err_o, 0);

    // Minimum ratio 2, five periods
    div_ratio_i = 6'd2; div_load_i = 1'b1;
    step();
    div_load_i = 1'b0;
    enable_i = 1'b1;
    wait_strobe(ok);
    check("r2_start", ok, 1);
    for (int i = 0; i < 5; i++) begin
      meas(hi, lo);
      check($sformatf("r2_hi%0d", i), hi, 1);
      check($sformatf("r2_lo%0d", i), lo, 1);
    end
`ifdef LF_PERIOD_CNT_EN
    check("pcnt_5", period_cnt_o, 5);
`endif
    div_ratio_i = 6'd4; div_load_i = 1'b1;
    step();
    div_load_i = 1'b0;
    wait_strobe(ok);
    check("r4b_cur", cur_ratio_o, 4);
`ifdef LF_PERIOD_CNT_EN
    check("pcnt_clr", period_cnt_o, 0);
`endif
    meas(hi, lo);
`ifdef LF_PERIOD_CNT_EN
    check("pcnt_1", period_cnt_o, 1);
`endif

    // Asynchronous reset mid-period while clk_lf_o is high
    step();
    check("pre_rst_clk", clk_lf_o, 1);
    #2;
    por_rstn_s = 1'b0;
    #1;
    check("arst_clk", clk_lf_o, 0);
    check("arst_strobe", lf_strobe_o, 0);
    check("arst_busy", div_busy_o, 0);
    check("arst_err", div_err_o, 0);
    check("arst_cur", cur_ratio_o, 16);
`ifdef LF_PERIOD_CNT_EN
    check("arst_pcnt", period_cnt_o, 0);
`endif
    steps(3);
    check("arst_hold_clk", clk_lf_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
